// File: rtl/song_tutor.sv
// rtl/song_tutor.sv - programmable melody tutor: song store, note follower, LED prompt
// Songs are written while idle; a started song is walked note by note with press/release pairing.
module song_tutor #(
  parameter int NOTE_W    = 4,
  parameter int NONE_CODE = 0,
  parameter int MAX_LEN   = 64,
  parameter int NUM_SONGS = 4,
  parameter int LED_W     = 8,
  parameter int ERR_W     = 8,
  localparam int AW = $clog2(MAX_LEN),
  localparam int SW = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int LW = AW + 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              STRICT,
  input  logic [SW-1:0]     song_sel,
  input  logic [NOTE_W-1:0] note,
  input  logic              prog_we,
  input  logic [SW-1:0]     prog_song,
  input  logic [AW-1:0]     prog_addr,
  input  logic [NOTE_W-1:0] prog_note,
  input  logic              prog_len_we,
  input  logic [LW-1:0]     prog_len,
  output logic [LED_W-1:0]  Led,
  output logic [AW-1:0]     idx,
  output logic              busy,
  output logic              done,
  output logic              wrong,
  output logic [ERR_W-1:0]  err_count
);

  localparam logic [NOTE_W-1:0] NONE = NOTE_W'(NONE_CODE);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE, S_WRELEASE} state_t;

  state_t            r_state;
  logic [NOTE_W-1:0] r_mem [NUM_SONGS][MAX_LEN];
  logic [LW-1:0]     r_len [NUM_SONGS];
  logic [SW-1:0]     r_song;
  logic              r_strict;
  logic [AW-1:0]     r_idx;
  logic [ERR_W-1:0]  r_err;
  logic              r_busy;
  logic              r_done;
  logic              r_wrong;
  logic [LED_W-1:0]  r_led;

  logic              w_wr_ok;
  logic [LW-1:0]     w_len_clamped;
  logic [NOTE_W-1:0] w_exp;
  logic [LW-1:0]     w_cur_len;
  logic              w_last;
  logic              w_note_none;
  logic [LED_W-1:0]  w_led_next;

  // The song store is frozen while a song runs so the expected note never shifts underfoot.
  assign w_wr_ok       = !r_busy && !START;
  assign w_len_clamped = (prog_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : prog_len;
  assign w_exp         = r_mem[r_song][r_idx];
  assign w_cur_len     = r_len[r_song];
  assign w_last        = ({1'b0, r_idx} == (w_cur_len - LW'(1)));
  assign w_note_none   = (note == NONE);

  always_comb begin
    w_led_next = '0;
    if (r_state != S_IDLE && w_exp != NONE && w_exp != '0 &&
        (32'(w_exp) <= 32'(LED_W)))
      w_led_next = LED_W'(1) << (w_exp - NOTE_W'(1));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int s = 0; s < NUM_SONGS; s++) begin
        r_len[s] <= '0;
        for (int a = 0; a < MAX_LEN; a++) r_mem[s][a] <= NONE;
      end
    end else begin
      if (prog_we && w_wr_ok) r_mem[prog_song][prog_addr] <= prog_note;
      if (prog_len_we && w_wr_ok) r_len[prog_song] <= w_len_clamped;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= S_IDLE;
      r_song   <= '0;
      r_strict <= 1'b0;
      r_idx    <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wrong  <= 1'b0;
      r_led    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_wrong <= 1'b0;
      r_led   <= w_led_next;
      if (START) begin
        r_song   <= song_sel;
        r_strict <= STRICT;
        r_idx    <= '0;
        r_err    <= '0;
        if (r_len[song_sel] == '0) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end else begin
          r_busy  <= 1'b1;
          r_state <= S_PRESS;
        end
      end else begin
        case (r_state)
          S_IDLE: ;
          S_PRESS: begin
            if (note == w_exp) begin
              r_state <= S_RELEASE;
            end else if (!w_note_none) begin
              r_wrong <= 1'b1;
              if (r_err != '1) r_err <= r_err + ERR_W'(1);
              if (r_strict) r_idx <= '0;
              r_state <= S_WRELEASE;
            end
          end
          S_RELEASE: begin
            if (w_note_none) begin
              if (w_last) begin
                r_done  <= 1'b1;
                r_idx   <= '0;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_idx   <= r_idx + AW'(1);
                r_state <= S_PRESS;
              end
            end
          end
          S_WRELEASE: begin
            if (w_note_none) r_state <= S_PRESS;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign Led       = r_led;
  assign idx       = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign wrong     = r_wrong;
  assign err_count = r_err;

endmodule
